// File: rtl/key_debouncer.sv
// key_debouncer: 2-flop synchronizer, per-channel stability counter, press/release strobes.
// Define KEY_AUTOREPEAT_EN to add press auto-repeat while a key stays held.
module key_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_pulse
);

    localparam int   CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic IDLE = (ACTIVE_LOW != 0);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad
        $error("key_debouncer: illegal timing parameters");
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          p;
        logic          hit;
        logic          rfire;
        logic          lvl;
        logic          pr;
        logic          rl;
        logic [CW-1:0] cnt;

        assign p   = (ACTIVE_LOW != 0) ? ~s2 : s2;
        assign hit = (p != lvl) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1  <= IDLE;
                s2  <= IDLE;
                cnt <= '0;
                lvl <= 1'b0;
                pr  <= 1'b0;
                rl  <= 1'b0;
            end else begin
                s1 <= raw[i];
                s2 <= s1;
                pr <= (hit & p) | rfire;
                rl <= hit & ~p;
                if (p == lvl) begin
                    cnt <= '0;
                end else if (hit) begin
                    lvl <= p;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

`ifdef KEY_AUTOREPEAT_EN
        logic [RW-1:0] rcnt;
        logic          rep;
        logic [RW-1:0] rtgt;

        // first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
        assign rtgt  = rep ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
        assign rfire = lvl && !hit && (rcnt == rtgt);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rcnt <= '0;
                rep  <= 1'b0;
            end else if (hit || !lvl) begin
                rcnt <= '0;
                rep  <= 1'b0;
            end else if (rfire) begin
                rcnt <= '0;
                rep  <= 1'b1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
        end
`else
        assign rfire = 1'b0;
`endif

        assign level[i]         = lvl;
        assign press[i]         = pr;
        assign release_pulse[i] = rl;
    end

endmodule
